// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Matrix-keypad scanner. Strobes one column at a time (one-hot, active-high)
// and samples the active-high row lines once per scan tick. A single-row hit
// is debounced for DEBOUNCE ticks before it is confirmed as a key event. The
// key is then held until DEBOUNCE consecutive release ticks are seen. Each
// confirmed press is placed in a one-deep event register with a valid/ack
// handshake. A press that arrives while the previous event is still
// unacknowledged is dropped and flagged on a sticky overrun bit.
//
// All logic runs on clk. The scan tick is an internal enable, not a clock.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   key_row    row sense lines, active-high, already synchronised
//   key_col    one-hot column strobe; all-zero while idle
//   key_valid  pending key event present
//   key_code   code of the pending event = row_idx*COLS + col_idx
//   key_ack    consumer acknowledge for the pending event
//   key_held   debounced key is still down
//   overrun    sticky: an event was dropped while one was pending
//
// State table
//   state      | meaning
//   S_IDLE     | after reset, no column driven; waits for the first tick
//   S_SCAN     | strobing col_idx, looking for exactly one active row
//   S_PRESS_DB | single row seen, counting stable press ticks
//   S_HELD     | press confirmed, waiting for the row pattern to change
//   S_REL_DB   | row pattern changed, counting stable release ticks
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 3,
    parameter int SCAN_DIV = 12500,
    parameter int DEBOUNCE = 4,
    parameter int CODE_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   key_row,
    output logic [COLS-1:0]   key_col,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    input  logic              key_ack,
    output logic              key_held,
    output logic              overrun
);

    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int CIDX_W = $clog2(COLS);
    localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SCAN     = 3'd1,
        S_PRESS_DB = 3'd2,
        S_HELD     = 3'd3,
        S_REL_DB   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Scan tick generator
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;

    assign w_tick = (r_div_cnt == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scanner state
    // ------------------------------------------------------------------
    state_t            r_state,    w_state_nxt;
    logic [CIDX_W-1:0] r_col_idx,  w_col_nxt;
    logic [RIDX_W-1:0] r_row_idx,  w_row_idx_nxt;
    logic [ROWS-1:0]   r_row_oh,   w_row_oh_nxt;
    logic [7:0]        r_db_cnt,   w_db_nxt;
    logic              w_confirm;

    // Row sample decode
    logic              w_samp_one;
    logic [RIDX_W-1:0] w_samp_idx;
    logic              w_row_eq;
    logic [CIDX_W-1:0] w_col_adv;
    logic              w_db_done;

    always_comb begin
        w_samp_one = ($countones(key_row) == 1);
        w_samp_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (key_row[i]) begin
                w_samp_idx = RIDX_W'(i);
            end
        end
    end

    // A multi-key sample can never equal the latched one-hot pattern, so it
    // naturally counts as "different" in the debounce and held states.
    assign w_row_eq  = (key_row == r_row_oh);
    assign w_col_adv = (int'(r_col_idx) == COLS - 1) ? '0 : r_col_idx + 1'b1;
    // True when this tick is the DEBOUNCE-th consecutive matching one.
    assign w_db_done = ((int'(r_db_cnt) + 1) >= DEBOUNCE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_col_idx <= '0;
            r_row_idx <= '0;
            r_row_oh  <= '0;
            r_db_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_col_idx <= w_col_nxt;
            r_row_idx <= w_row_idx_nxt;
            r_row_oh  <= w_row_oh_nxt;
            r_db_cnt  <= w_db_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col_idx;
        w_row_idx_nxt = r_row_idx;
        w_row_oh_nxt  = r_row_oh;
        w_db_nxt      = r_db_cnt;
        w_confirm     = 1'b0;

        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_SCAN;
                    w_col_nxt   = '0;
                end

                S_SCAN: begin
                    if (w_samp_one) begin
                        w_row_idx_nxt = w_samp_idx;
                        w_row_oh_nxt  = key_row;
                        w_db_nxt      = 8'd1;
                        if (DEBOUNCE == 1) begin
                            w_state_nxt = S_HELD;
                            w_confirm   = 1'b1;
                        end else begin
                            w_state_nxt = S_PRESS_DB;
                        end
                    end else begin
                        w_col_nxt = w_col_adv;
                    end
                end

                S_PRESS_DB: begin
                    if (w_row_eq) begin
                        if (w_db_done) begin
                            w_state_nxt = S_HELD;
                            w_confirm   = 1'b1;
                        end else begin
                            w_db_nxt = r_db_cnt + 8'd1;
                        end
                    end else begin
                        // Bounce: abandon the press silently and move on.
                        w_state_nxt = S_SCAN;
                        w_col_nxt   = w_col_adv;
                    end
                end

                S_HELD: begin
                    if (!w_row_eq) begin
                        if (DEBOUNCE == 1) begin
                            w_state_nxt = S_SCAN;
                            w_col_nxt   = w_col_adv;
                        end else begin
                            w_state_nxt = S_REL_DB;
                            w_db_nxt    = 8'd1;
                        end
                    end
                end

                S_REL_DB: begin
                    if (w_row_eq) begin
                        w_state_nxt = S_HELD;
                    end else if (w_db_done) begin
                        w_state_nxt = S_SCAN;
                        w_col_nxt   = w_col_adv;
                    end else begin
                        w_db_nxt = r_db_cnt + 8'd1;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Column strobe and held flag, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        key_col = '0;
        if (r_state != S_IDLE) begin
            key_col[r_col_idx] = 1'b1;
        end
    end

    assign key_held = (r_state == S_HELD) || (r_state == S_REL_DB);

    // ------------------------------------------------------------------
    // Event register with valid/ack handshake
    // ------------------------------------------------------------------
    logic [RIDX_W-1:0] w_code_row;
    logic [CODE_W-1:0] w_code;
    logic              r_key_valid;
    logic [CODE_W-1:0] r_key_code;
    logic              r_overrun;

    // With DEBOUNCE=1 the confirm happens on the same tick the row is first
    // seen, before the row index has been latched.
    assign w_code_row = (r_state == S_SCAN) ? w_samp_idx : r_row_idx;
    assign w_code     = CODE_W'(w_code_row) * CODE_W'(COLS) + CODE_W'(r_col_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_overrun   <= 1'b0;
        end else if (w_confirm) begin
            if (!r_key_valid || key_ack) begin
                // Slot free, or the old event is consumed this very clock.
                r_key_valid <= 1'b1;
                r_key_code  <= w_code;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_key_valid && key_ack) begin
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Bench for keypad_scanner with ROWS=4, COLS=3, SCAN_DIV=4, DEBOUNCE=3.
// Reset is released on a falling edge; that falling edge is cycle 0. Scan
// period p covers cycles 4p..4p+3, its tick is cycle 4p+3 and the state
// update lands on the edge before cycle 4p+4. Each table row gives the row
// pattern driven for one period, the ack mode, and the outputs expected at
// cycle 4p+4. Ack mode 1 pulses ack in the first clk of the period, mode 2
// in the tick clk.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ack;
    logic       key_held;
    logic       overrun;

    int n_chk;
    int n_err;

    keypad_scanner #(
        .ROWS    (4),
        .COLS    (3),
        .SCAN_DIV(4),
        .DEBOUNCE(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ack  (key_ack),
        .key_held (key_held),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] row;
        int         ack;
        logic [2:0] col;
        logic       valid;
        logic [3:0] code;
        logic       held;
        logic       ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] row, input int ack, input logic [2:0] col,
                       input logic valid, input logic [3:0] code,
                       input logic held, input logic ovr);
        vec_t v;
        v.row   = row;
        v.ack   = ack;
        v.col   = col;
        v.valid = valid;
        v.code  = code;
        v.held  = held;
        v.ovr   = ovr;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_col"},   0, 32'(key_col),   32'h0);
        chk({tag, "_valid"}, 0, 32'(key_valid), 32'h0);
        chk({tag, "_code"},  0, 32'(key_code),  32'h0);
        chk({tag, "_held"},  0, 32'(key_held),  32'h0);
        chk({tag, "_ovr"},   0, 32'(overrun),   32'h0);
    endtask

    initial begin
        logic [2:0] prev_col;

        n_chk   = 0;
        n_err   = 0;
        rst     = 1'b1;
        key_row = 4'b0000;
        key_ack = 1'b0;

        //   row     ack col     v  code  h  ovr
        add(4'b0000, 0, 3'b001, 0, 4'd0, 0, 0); // p0  idle -> scan col0
        add(4'b0000, 0, 3'b010, 0, 4'd0, 0, 0); // p1  advance
        add(4'b0100, 0, 3'b010, 0, 4'd0, 0, 0); // p2  row2@col1 seen
        add(4'b0100, 0, 3'b010, 0, 4'd0, 0, 0); // p3
        add(4'b0100, 0, 3'b010, 1, 4'd7, 1, 0); // p4  confirm code 7
        add(4'b0100, 1, 3'b010, 0, 4'd0, 1, 0); // p5  ack
        add(4'b0000, 0, 3'b010, 0, 4'd0, 1, 0); // p6  release 1
        add(4'b0000, 0, 3'b010, 0, 4'd0, 1, 0); // p7  release 2
        add(4'b0000, 0, 3'b100, 0, 4'd0, 0, 0); // p8  release 3 -> col2
        add(4'b0001, 0, 3'b100, 0, 4'd0, 0, 0); // p9  bounce start
        add(4'b0001, 0, 3'b100, 0, 4'd0, 0, 0); // p10
        add(4'b0000, 0, 3'b001, 0, 4'd0, 0, 0); // p11 bounce lost -> col0
        add(4'b0011, 0, 3'b010, 0, 4'd0, 0, 0); // p12 multi-key ignored
        add(4'b1010, 0, 3'b100, 0, 4'd0, 0, 0); // p13 multi-key ignored
        add(4'b0000, 0, 3'b001, 0, 4'd0, 0, 0); // p14
        add(4'b1000, 0, 3'b001, 0, 4'd0, 0, 0); // p15 row3@col0
        add(4'b1000, 0, 3'b001, 0, 4'd0, 0, 0); // p16
        add(4'b1000, 0, 3'b001, 1, 4'd9, 1, 0); // p17 confirm code 9
        add(4'b0000, 0, 3'b001, 1, 4'd9, 1, 0); // p18
        add(4'b0000, 0, 3'b001, 1, 4'd9, 1, 0); // p19
        add(4'b0000, 0, 3'b010, 1, 4'd9, 0, 0); // p20 -> col1
        add(4'b0001, 0, 3'b010, 1, 4'd9, 0, 0); // p21 row0@col1
        add(4'b0001, 0, 3'b010, 1, 4'd9, 0, 0); // p22
        add(4'b0001, 0, 3'b010, 1, 4'd9, 1, 1); // p23 dropped -> overrun
        add(4'b0000, 1, 3'b010, 0, 4'd0, 1, 0); // p24 ack clears both
        add(4'b0000, 0, 3'b010, 0, 4'd0, 1, 0); // p25
        add(4'b0000, 0, 3'b100, 0, 4'd0, 0, 0); // p26 -> col2
        add(4'b0010, 0, 3'b100, 0, 4'd0, 0, 0); // p27 row1@col2
        add(4'b0010, 0, 3'b100, 0, 4'd0, 0, 0); // p28
        add(4'b0010, 0, 3'b100, 1, 4'd5, 1, 0); // p29 confirm code 5
        add(4'b0000, 0, 3'b100, 1, 4'd5, 1, 0); // p30
        add(4'b0000, 0, 3'b100, 1, 4'd5, 1, 0); // p31
        add(4'b0000, 0, 3'b001, 1, 4'd5, 0, 0); // p32 -> col0
        add(4'b0100, 0, 3'b001, 1, 4'd5, 0, 0); // p33 row2@col0
        add(4'b0100, 0, 3'b001, 1, 4'd5, 0, 0); // p34
        add(4'b0100, 0, 3'b001, 1, 4'd5, 1, 1); // p35 dropped -> overrun
        add(4'b0000, 0, 3'b001, 1, 4'd5, 1, 1); // p36
        add(4'b0000, 0, 3'b001, 1, 4'd5, 1, 1); // p37
        add(4'b0000, 0, 3'b010, 1, 4'd5, 0, 1); // p38 -> col1
        add(4'b0100, 0, 3'b010, 1, 4'd5, 0, 1); // p39 row2@col1
        add(4'b0100, 0, 3'b010, 1, 4'd5, 0, 1); // p40
        add(4'b0100, 2, 3'b010, 1, 4'd7, 1, 1); // p41 ack with confirm: new code, ovr kept
        add(4'b0000, 0, 3'b010, 1, 4'd7, 1, 1); // p42
        add(4'b0000, 0, 3'b010, 1, 4'd7, 1, 1); // p43
        add(4'b0000, 0, 3'b100, 1, 4'd7, 0, 1); // p44 -> col2

        step(3);
        chk_reset_outputs("rst_init");
        rst = 1'b0;                           // cycle 0

        prev_col = 3'b000;
        for (int p = 0; p < tbl.size(); p++) begin
            key_row = tbl[p].row;
            key_ack = (tbl[p].ack == 1);
            step(1);
            key_ack = 1'b0;
            chk("col_hold", p, 32'(key_col), 32'(prev_col));
            step(1);
            chk("col_hold", p, 32'(key_col), 32'(prev_col));
            step(1);
            chk("col_hold", p, 32'(key_col), 32'(prev_col));
            key_ack = (tbl[p].ack == 2);
            step(1);
            key_ack = 1'b0;
            chk("col",   p, 32'(key_col),   32'(tbl[p].col));
            chk("valid", p, 32'(key_valid), 32'(tbl[p].valid));
            chk("held",  p, 32'(key_held),  32'(tbl[p].held));
            chk("ovr",   p, 32'(overrun),   32'(tbl[p].ovr));
            if (tbl[p].valid) begin
                chk("code", p, 32'(key_code), 32'(tbl[p].code));
            end
            prev_col = tbl[p].col;
        end

        // Reset during PRESS_DB, with an unacked event and overrun pending.
        key_row = 4'b0001;                    // row0@col2
        step(4);
        chk("pdb_entry_col",  0, 32'(key_col),  32'h4);
        chk("pdb_entry_held", 0, 32'(key_held), 32'h0);
        step(2);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_pdb");
        key_row = 4'b0000;
        step(2);
        rst = 1'b0;                           // cycle 0 again
        step(16);
        chk("post_rst1_col",   0, 32'(key_col),   32'h1);
        chk("post_rst1_valid", 0, 32'(key_valid), 32'h0);
        chk("post_rst1_held",  0, 32'(key_held),  32'h0);
        chk("post_rst1_ovr",   0, 32'(overrun),   32'h0);

        // Fresh press row0@col0 -> code 0, then reset while HELD.
        key_row = 4'b0001;
        step(12);
        chk("held_valid", 0, 32'(key_valid), 32'h1);
        chk("held_code",  0, 32'(key_code),  32'h0);
        chk("held_held",  0, 32'(key_held),  32'h1);
        chk("held_col",   0, 32'(key_col),   32'h1);
        step(1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_held");
        key_row = 4'b0000;
        step(2);
        rst = 1'b0;
        step(20);
        chk("post_rst2_col",   0, 32'(key_col),   32'h2);
        chk("post_rst2_valid", 0, 32'(key_valid), 32'h0);
        chk("post_rst2_held",  0, 32'(key_held),  32'h0);
        chk("post_rst2_ovr",   0, 32'(overrun),   32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
